// File: rtl/gdiv_pkg.sv
// Shared types and helpers for the stochastic divider front-end generators.
package gdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_t;

  localparam int LFSR_BW_MIN = 3;
  localparam int LFSR_BW_MAX = 8;

  // Fibonacci feedback taps (bit i = state[i] feeds the XOR), maximal-length polynomials.
  function automatic logic [7:0] lfsr_taps(input int bw);
    logic [7:0] t;
    case (bw)
      3:       t = 8'h06;  // x^3+x^2+1
      4:       t = 8'h0C;  // x^4+x^3+1
      5:       t = 8'h14;  // x^5+x^3+1
      6:       t = 8'h30;  // x^6+x^5+1
      7:       t = 8'h60;  // x^7+x^6+1
      8:       t = 8'hB8;  // x^8+x^6+x^5+x^4+1
      default: t = 8'h0C;
    endcase
    return t;
  endfunction

  // Reverses the low bw bits of v; upper bits of v must be zero.
  function automatic logic [7:0] bit_rev(input logic [7:0] v, input int bw);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r >> (8 - bw);
  endfunction

endpackage

// File: rtl/gdiv_lfsr_db.sv
// De Bruijn-extended Fibonacci LFSR: visits all 2^BW states, including zero, once per period.
module gdiv_lfsr_db
  import gdiv_pkg::*;
#(
  parameter int            BW      = 4,
  parameter logic [BW-1:0] RST_VAL = {1'b1, {(BW-1){1'b0}}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [BW-1:0] seed,
  output logic [BW-1:0] state
);

  localparam logic [7:0]    TAPS8 = lfsr_taps(BW);
  localparam logic [BW-1:0] TAPS  = TAPS8[BW-1:0];

  logic [BW-1:0] state_q, state_d;
  logic          fb;

  // The NOR term splices the zero state in between 10..0 and 0..01.
  always_comb begin
    fb      = (^(state_q & TAPS)) ^ (state_q[BW-2:0] == '0);
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = {state_q[BW-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/gdiv_sng4b.sv
// Stochastic number generator feeding the gated divider: one 2^BW-cycle unary window per operand pair.
// Build option GDIV_SNG_LFSR_RESEED_EN reloads the LFSR on accept and advances it only inside windows.
// state | meaning
// IDLE  | no window running, operand pair can be taken
// RUN   | window running, cnt_q is the window index
module gdiv_sng4b
  import gdiv_pkg::*;
#(
  parameter int            BW   = 4,
  parameter logic [BW-1:0] SEED = {1'b1, {(BW-1){1'b0}}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] dividend_bin,
  input  logic [BW-1:0] divisor_bin,
  output logic          dividend,
  output logic          divisor,
  output logic [BW-1:0] randNum,
  output logic          stream_valid,
  output logic          first,
  output logic          last
);

  localparam logic [BW-1:0] CNT_MAX = '1;

  sng_state_t    state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] dvd_q, dvd_d;
  logic [BW-1:0] dvs_q, dvs_d;
  logic          sv_q, sv_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          accept;
  logic          lfsr_en, lfsr_load;
  logic [7:0]    rng_a;

  assign in_ready = (state_q == IDLE) | last_q;
  assign accept   = in_valid & in_ready;

  // An accept can only happen in IDLE or on the last window cycle, so it always restarts at index 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      dvd_d   = dividend_bin;
      dvs_d   = divisor_bin;
    end else if (state_q == RUN) begin
      if (cnt_q == CNT_MAX) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    sv_d    = (state_d == RUN);
    first_d = sv_d && (cnt_d == '0);
    last_d  = sv_d && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sv_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sv_q    <= sv_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Both streams compare against the same van der Corput value, keeping them fully correlated.
  assign rng_a        = bit_rev(8'(cnt_q), BW);
  assign dividend     = sv_q & (8'(dvd_q) > rng_a);
  assign divisor      = sv_q & (8'(dvs_q) > rng_a);
  assign stream_valid = sv_q;
  assign first        = first_q;
  assign last         = last_q;

`ifdef GDIV_SNG_LFSR_RESEED_EN
  assign lfsr_en   = sv_q;
  assign lfsr_load = accept;
`else
  assign lfsr_en   = 1'b1;
  assign lfsr_load = 1'b0;
`endif

  gdiv_lfsr_db #(
    .BW      (BW),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .load  (lfsr_load),
    .seed  (SEED),
    .state (randNum)
  );

endmodule

// File: tb/tb_gdiv_sng4b.sv
// Self-checking bench for gdiv_sng4b (BW=4): window-level reference model plus directed literal checks.
module tb_gdiv_sng4b;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] dividend_bin = 4'd0;
  logic [3:0] divisor_bin = 4'd0;
  logic       in_ready, dividend, divisor, stream_valid, first, last;
  logic [3:0] randNum;

  gdiv_sng4b #(.BW(4), .SEED(4'b1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend_bin (dividend_bin),
    .divisor_bin  (divisor_bin),
    .dividend     (dividend),
    .divisor      (divisor),
    .randNum      (randNum),
    .stream_valid (stream_valid),
    .first        (first),
    .last         (last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-derived: de Bruijn x^4+x^3+1 orbit starting at 4'b1000, and bit-reversed window order.
  int lfsr_seq[16]  = '{8, 0, 1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12};
  int rng_a_seq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // Reference model: window position, latched operands, and number of LFSR advances.
  logic m_run;
  int   m_idx, m_a, m_b, m_adv;
  logic m_rdy;
  assign m_rdy = !m_run || (m_idx == N - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_idx <= 0;
      m_a   <= 0;
      m_b   <= 0;
      m_adv <= 0;
    end else begin
`ifdef GDIV_SNG_LFSR_RESEED_EN
      if (in_valid && m_rdy) m_adv <= 0;
      else if (m_run) m_adv <= m_adv + 1;
`else
      m_adv <= m_adv + 1;
`endif
      if (in_valid && m_rdy) begin
        m_run <= 1'b1;
        m_idx <= 0;
        m_a   <= int'(dividend_bin);
        m_b   <= int'(divisor_bin);
      end else if (m_run) begin
        if (m_idx == N - 1) m_run <= 1'b0;
        else m_idx <= m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    cmp("in_ready", int'(in_ready), int'(m_rdy));
    cmp("stream_valid", int'(stream_valid), int'(m_run));
    cmp("first", int'(first), int'(m_run && m_idx == 0));
    cmp("last", int'(last), int'(m_run && m_idx == N - 1));
    cmp("dividend", int'(dividend), int'(m_run && (m_a > rng_a_seq[m_idx])));
    cmp("divisor", int'(divisor), int'(m_run && (m_b > rng_a_seq[m_idx])));
    cmp("randNum", int'(randNum), lfsr_seq[m_adv % N]);
  end

  logic [15:0] c_dvd, c_dvs, c_first, c_last, c_rdy, c_sv;
  int          c_rn[16];
  int          rn1[16];
  logic [15:0] seen;

  // Called on a negedge; returns on the negedge of window index 0.
  task automatic offer(input int a, input int b);
    dividend_bin = 4'(a);
    divisor_bin  = 4'(b);
    in_valid     = 1'b1;
    for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
    cmp("accept_wait", int'(in_ready), 1);
    @(negedge clk);
  endtask

  // Samples one window from index 0; after index 0 presents the next offer (nv, na, nb).
  task automatic capture(input logic nv, input int na, input int nb);
    for (int i = 0; i < N; i++) begin
      c_dvd[i]   = dividend;
      c_dvs[i]   = divisor;
      c_first[i] = first;
      c_last[i]  = last;
      c_rdy[i]   = in_ready;
      c_sv[i]    = stream_valid;
      c_rn[i]    = int'(randNum);
      if (i == 0) begin
        in_valid     = nv;
        dividend_bin = 4'(na);
        divisor_bin  = 4'(nb);
      end
      if (i < N - 1) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    cmp("rst_in_ready", int'(in_ready), 1);
    cmp("rst_randNum", int'(randNum), 8);
    cmp("rst_outputs", int'({stream_valid, first, last, dividend, divisor}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmp("idle_in_ready", int'(in_ready), 1);
      cmp("idle_outputs", int'({stream_valid, first, last, dividend, divisor}), 0);
    end

    // (5,10), then the same pair after a 7-cycle idle gap
    offer(5, 10);
    capture(1'b0, 0, 0);
    rn1 = c_rn;
    cmp("w510_dvd_pattern", int'(c_dvd), 'h1115);
    cmp("w510_dvs_ones", $countones(c_dvs), 10);
    cmp("w510_dvd_within_dvs", int'(c_dvd & ~c_dvs), 0);
    cmp("w510_first_pos", int'(c_first), 'h0001);
    cmp("w510_last_pos", int'(c_last), 'h8000);
    cmp("w510_valid_all", int'(c_sv), 'hFFFF);
    seen = '0;
    for (int i = 0; i < N; i++) seen[c_rn[i]] = 1'b1;
    cmp("w510_randNum_perm", int'(seen), 'hFFFF);
`ifdef GDIV_SNG_LFSR_RESEED_EN
    cmp("w510_randNum_start", rn1[0], 8);
`endif
    @(negedge clk);
    cmp("after_last_idle", int'({stream_valid, dividend, divisor}), 0);
    repeat (6) @(negedge clk);
    offer(5, 10);
    capture(1'b0, 0, 0);
    for (int i = 0; i < N; i++) begin
`ifdef GDIV_SNG_LFSR_RESEED_EN
      cmp("gap_randNum_repeat", c_rn[i], rn1[i]);
`else
      cmp("gap_randNum_rot23", c_rn[i], rn1[(i + 23) % N]);
`endif
    end

    // back-to-back (3,7) then (6,6)
    @(negedge clk);
    offer(3, 7);
    capture(1'b1, 6, 6);
    cmp("b2b_a_dvd_ones", $countones(c_dvd), 3);
    cmp("b2b_a_dvs_ones", $countones(c_dvs), 7);
    cmp("b2b_a_ready_only_last", int'(c_rdy), 'h8000);
    @(negedge clk);
    capture(1'b0, 0, 0);
    cmp("b2b_b_first_no_bubble", int'(c_first), 'h0001);
    cmp("b2b_b_valid_all", int'(c_sv), 'hFFFF);
    cmp("b2b_b_dvd_eq_dvs", int'(c_dvd), int'(c_dvs));
    cmp("b2b_b_dvd_ones", $countones(c_dvd), 6);

    // asynchronous reset at window index 9
    @(negedge clk);
    offer(9, 13);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    cmp("idx9_running", int'(stream_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("abort_outputs", int'({stream_valid, first, last, dividend, divisor}), 0);
    cmp("abort_in_ready", int'(in_ready), 1);
    cmp("abort_randNum", int'(randNum), 8);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("post_rst_in_ready", int'(in_ready), 1);
    offer(2, 4);
    capture(1'b0, 0, 0);
    cmp("post_rst_first_pos", int'(c_first), 'h0001);
    cmp("post_rst_dvd_ones", $countones(c_dvd), 2);
    cmp("post_rst_dvs_ones", $countones(c_dvs), 4);

    // edge operands
    @(negedge clk);
    offer(0, 0);
    capture(1'b0, 0, 0);
    cmp("zero_dvd", int'(c_dvd), 0);
    cmp("zero_dvs", int'(c_dvs), 0);
    @(negedge clk);
    offer(15, 15);
    capture(1'b0, 0, 0);
    cmp("full_dvd", int'(c_dvd), 'h7FFF);
    cmp("full_dvs", int'(c_dvs), 'h7FFF);
    @(negedge clk);
    offer(12, 4);
    capture(1'b0, 0, 0);
    cmp("sat_dvd_ones", $countones(c_dvd), 12);
    cmp("sat_dvs_ones", $countones(c_dvs), 4);
    cmp("sat_dvs_within_dvd", int'(c_dvs & ~c_dvd), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gdiv_sng4b.md
# gdiv_sng4b

Stochastic number generator placed directly upstream of the 4-bit gated stochastic divider. It accepts a binary dividend/divisor pair through a valid/ready handshake and emits one 2^BW-cycle window of correlated unary bitstreams. During that window it also drives the divider's `randNum` comparison input from an independent de Bruijn LFSR. One accepted operand pair produces exactly one window, and back-to-back windows are supported.

## Interface
- `BW`, default 4: operand/random width; supported 3..8; window length 2^BW.
- `SEED`, default 4'b1000 (BW bits): LFSR reset/reload value.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: operand pair can be accepted this cycle.
- `dividend_bin` input BW: binary dividend.
- `divisor_bin` input BW: binary divisor.
- `dividend` output 1: dividend bitstream bit.
- `divisor` output 1: divisor bitstream bit.
- `randNum` output BW: random value for the divider's comparator.
- `stream_valid` output 1: high on every window cycle.
- `first` output 1: window index 0.
- `last` output 1: window index 2^BW-1.

## Operation
- States: IDLE and RUN.
- Accept happens when `in_valid & in_ready`. On accept, latch both operands, clear window counter `cnt`, and go to RUN.
- `in_ready` = (state==IDLE) | (state==RUN & `last`).
- In RUN, `cnt` increments every cycle. At `cnt`==2^BW-1:
  - if an accept occurs that cycle, stay in RUN, reload operands, and set `cnt`=0;
  - otherwise return to IDLE.
- `cnt` wraps only through this path.
- Source A is `rngA` = bit-reverse(`cnt`), a low-discrepancy sequence. For BW=4 the order is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- `dividend` = `stream_valid` & (`dividend_reg` > `rngA`).
- `divisor` = `stream_valid` & (`divisor_reg` > `rngA`).
- Both streams share source A, so they are maximally correlated, which the gated divider requires.
- Ones counts per window are exact: `dividend_bin` ones in the dividend stream and `divisor_bin` ones in the divisor stream.
- Source B is a Fibonacci LFSR, x^4+x^3+1 for BW=4 (tap table in the package), extended with the all-zero state by de Bruijn NOR correction. Its 2^BW advances visit every value 0..2^BW-1 once. `randNum` = LFSR state.
- No range checks:
  - `dividend_bin` > `divisor_bin` is passed through unchanged (the divider saturates).
  - `divisor_bin`=0 gives an all-zero divisor stream.
- Outputs depend only on registers plus the comparators; there is no input-to-output combinational path except `in_valid` → nothing.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, operand registers 0, LFSR=`SEED`;
  - `in_ready`=1, `stream_valid`=0, `first`=0, `last`=0, `dividend`=0, `divisor`=0, `randNum`=`SEED`.
- Latency: an accept at edge k gives `stream_valid`=1 and `first`=1 from cycle k+1. `last` is high at cycle k+2^BW.
- Back-to-back: an accept in the `last` cycle makes the next cycle `first`, with no bubble.
- While in RUN and not on the `last` cycle, `in_ready`=0. Offered operands must be held by the source; they are never dropped or sampled.
- Reset asserted mid-window aborts asynchronously to the reset values. No partial window resumes after reset.
- `in_valid` deasserted at `last` puts the block in IDLE the next cycle, with all stream outputs 0.

## Configuration
- Macro: `GDIV_SNG_LFSR_RESEED_EN`.
- Defined: the LFSR reloads `SEED` on every accept and advances only while `stream_valid`. Every window therefore sees an identical `randNum` sequence, which makes the output fully deterministic per operand pair.
- Undefined: the LFSR advances on every clock, including IDLE, and is never reloaded after reset. The `randNum` phase then depends on idle gaps between windows.

## Structure
- Package `gdiv_pkg`:
  - state enum `sng_state_t` {IDLE, RUN};
  - LFSR tap-mask function/table indexed by BW (3..8);
  - bit-reverse function.
- Sub-module `gdiv_lfsr_db`: a de Bruijn-extended LFSR with ports clk, rst_n, `en`, `load`, `seed`, `state`. It is reusable by other stochastic generators in the codebase.

## Test plan
- Reset, then idle: `in_ready`=1, `randNum`=4'b1000, all stream outputs 0 for 20 cycles.
- Accept `dividend_bin`=5, `divisor_bin`=10: the dividend stream is 1 exactly at window indices 0,2,4,8,12 (5 ones), and the divisor stream has 10 ones. Every dividend 1 coincides with a divisor 1. `first` occurs at k+1 and `last` at k+16.
- Two pairs offered continuously, (3,7) then (6,6): the two windows run back-to-back with no gap, `in_ready` is high only on `last` cycles, and the second window's divisor stream equals its dividend stream.
- With `GDIV_SNG_LFSR_RESEED_EN` defined, run two windows with a 7-cycle idle gap: the `randNum` sequences are identical, and each window contains every value 0..15 once. Without the macro, the second sequence is rotated by 23 positions relative to the first.
- Assert `rst_n` low at window index 9: outputs go to reset values immediately. After release, `in_ready`=1 and the next accept starts a fresh window at index 0.
- Edge operands: (0,0) gives all-zero streams; (15,15) gives 15 ones each, with index 15 (`rngA`=15) being 0; (12,4) gives 12 vs 4 ones with no error flagged.
